// File: rtl/config_pkg.sv
// config_pkg -- shared config-bus constants, address field slices and loader states. Rev 1.0
`default_nettype none

package config_pkg;

    localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF;
    localparam logic [31:0] END_ADDR  = 32'hFFFF_FFFE;

    localparam int TILE_ID_MSB   = 31;
    localparam int TILE_ID_LSB   = 16;
    localparam int CONFIG_ID_MSB = 15;
    localparam int CONFIG_ID_LSB = 0;

    typedef enum logic [2:0] {
        S_ADDR = 3'd0,
        S_DATA = 3'd1,
        S_HOLD = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/config_loader.sv
// config_loader -- turns an (address, data) word stream into held writes on the tile config bus. Rev 1.0
`default_nettype none

module config_loader
    import config_pkg::*;
#(
    parameter int          HOLD_CYCLES = 2,
    parameter int          COUNT_W     = 16,
    parameter logic [31:0] IDLE_ADDR   = config_pkg::IDLE_ADDR,
    parameter logic [31:0] END_ADDR    = config_pkg::END_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [31:0]        config_addr,
    output logic [31:0]        config_data,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] write_count
);

    localparam int HC_W = $clog2(HOLD_CYCLES) + 1;

    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("config_loader: HOLD_CYCLES must be >= 1");
        end
    endgenerate

    loader_state_t    state;
    loader_state_t    state_next;
    logic [31:0]      addr_latch;
    logic [HC_W-1:0]  hold_cnt;
    logic             transfer;
    logic             hold_last;

    assign transfer  = in_valid && in_ready;
    assign hold_last = (hold_cnt == HC_W'(HOLD_CYCLES - 1));

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            S_ADDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == END_ADDR) begin
                        state_next = S_DONE;
                    end else if (in_data != IDLE_ADDR) begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                busy = 1'b1;
                if (hold_last) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                busy       = 1'b1;
                state_next = S_ADDR;
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_ADDR;
            end
        endcase
        // Nothing is accepted while the loader is being reset.
        if (!reset) begin
            in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_ADDR;
            addr_latch  <= '0;
            hold_cnt    <= '0;
            config_addr <= IDLE_ADDR;
            config_data <= '0;
            write_count <= '0;
            done        <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_ADDR: begin
                    if (transfer) begin
                        if (in_data == END_ADDR) begin
                            done <= 1'b1;
                        end else if (in_data != IDLE_ADDR) begin
                            addr_latch <= in_data;
                        end
                    end
                end
                S_DATA: begin
                    if (transfer) begin
                        config_addr <= addr_latch;
                        config_data <= in_data;
                        hold_cnt    <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_last) begin
                        config_addr <= IDLE_ADDR;
                        if (write_count != {COUNT_W{1'b1}}) begin
                            write_count <= write_count + 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
